// File: rtl/uart_cfg_top.sv
// Configurable UART transceiver: one transmitter and one receiver on one clock, with
// loopback select, parity generation/checking and first-stop-bit framing check.
module uart_cfg_top #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 tx_data_valid,
  input  logic [DATA_BITS-1:0] in,
  input  logic                 loopback,
  input  logic                 rx_serial_input,
  output logic                 tx_active,
  output logic                 tx_serial_data,
  output logic                 tx_done,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_output,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W   = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);
  localparam int HALF    = (CLKS_PER_BIT - 1) / 2;
  localparam bit HAS_PAR = (PARITY != 0);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_cfg_top: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Parity bit that makes data+parity satisfy the configured odd/even rule.
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  state_t               r_tx_state, w_tx_next;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [IDX_W-1:0]     r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_done;
  logic                 w_tx_line;
  logic                 w_tx_bit_end;
  logic                 w_tx_stop_end;
  logic                 w_tx_cnt_clr;

  assign w_tx_bit_end  = (r_tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_tx_stop_end = (r_tx_cnt == CNT_W'(STOP_BITS * CLKS_PER_BIT - 1));
  assign w_tx_cnt_clr  = (r_tx_state == S_IDLE) ||
                         ((r_tx_state == S_STOP) ? w_tx_stop_end : w_tx_bit_end);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_line = 1'b1;
    case (r_tx_state)
      S_IDLE:   if (tx_data_valid) w_tx_next = S_START;
      S_START: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) w_tx_next = S_DATA;
      end
      S_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end && r_tx_idx == IDX_W'(DATA_BITS - 1))
          w_tx_next = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_bit_end) w_tx_next = S_STOP;
      end
      S_STOP:   if (w_tx_stop_end) w_tx_next = S_IDLE;
      default:  w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_done  <= (r_tx_state == S_STOP) && w_tx_stop_end;
      r_tx_cnt   <= w_tx_cnt_clr ? '0 : r_tx_cnt + 1'b1;
      if (r_tx_state == S_IDLE)
        r_tx_idx <= '0;
      else if (r_tx_state == S_DATA && w_tx_bit_end)
        r_tx_idx <= r_tx_idx + 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (r_tx_state == S_IDLE && tx_data_valid) begin
      r_tx_shift <= in;
      r_tx_par   <= par_bit(in);
    end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
      r_tx_shift <= r_tx_shift >> 1;
    end
  end

  assign tx_serial_data = w_tx_line;
  assign tx_active      = (r_tx_state != S_IDLE);
  assign tx_done        = r_tx_done;

  state_t               r_rx_state, w_rx_next;
  logic                 r_sync1, r_sync2;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [IDX_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 r_rx_dv;
  logic [DATA_BITS-1:0] r_rx_out;
  logic                 r_rx_perr;
  logic                 r_rx_ferr;
  logic                 w_rx_line;
  logic                 w_rx_sample;
  logic                 w_rx_stop_smp;

  assign w_rx_line     = loopback ? w_tx_line : rx_serial_input;
  assign w_rx_sample   = (r_rx_cnt == '0);
  assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_rx_sample;

  // Start detection is held off during the valid pulse so a new frame begins one cycle later.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (!r_sync2 && !r_rx_dv) w_rx_next = S_START;
      S_START:  if (w_rx_sample) w_rx_next = r_sync2 ? S_IDLE : S_DATA;
      S_DATA:
        if (w_rx_sample && r_rx_idx == IDX_W'(DATA_BITS - 1))
          w_rx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_sample) w_rx_next = S_STOP;
      S_STOP:   if (w_rx_sample) w_rx_next = S_IDLE;
      default:  w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_dv    <= 1'b0;
      r_rx_out   <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_sync1    <= w_rx_line;
      r_sync2    <= r_sync1;
      r_rx_state <= w_rx_next;
      r_rx_dv    <= w_rx_stop_smp;
      if (r_rx_state == S_IDLE)
        r_rx_cnt <= CNT_W'(HALF - 1);
      else if (w_rx_sample)
        r_rx_cnt <= CNT_W'(CLKS_PER_BIT - 1);
      else
        r_rx_cnt <= r_rx_cnt - 1'b1;
      if (r_rx_state == S_IDLE)
        r_rx_idx <= '0;
      else if (r_rx_state == S_DATA && w_rx_sample)
        r_rx_idx <= r_rx_idx + 1'b1;
      if (w_rx_stop_smp) begin
        r_rx_out  <= r_rx_shift;
        r_rx_perr <= HAS_PAR && (r_rx_par != par_bit(r_rx_shift));
        r_rx_ferr <= ~r_sync2;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (r_rx_state == S_DATA && w_rx_sample)
      r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
    if (r_rx_state == S_PARITY && w_rx_sample)
      r_rx_par <= r_sync2;
  end

  assign rx_data_valid = r_rx_dv;
  assign rx_output     = r_rx_out;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;

endmodule
